// File: rtl/sad_result_collector.sv
// SAD result collector: buffers SAD results in a first-word fall-through FIFO
// with a sticky overflow flag, and tracks the per-frame minimum SAD.
module sad_result_collector #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cal_valid,
  input  logic [4:0]               cal_id,
  input  logic [15:0]              cal_rdata,
  input  logic                     frame_start,
  input  logic                     frame_end,
  input  logic                     ovf_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_id,
  output logic [15:0]              out_sad,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     ovf,
  output logic                     best_valid,
  output logic [15:0]              best_sad,
  output logic [4:0]               best_id,
  output logic [CNT_W-1:0]         best_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_e;

  logic [20:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, drop;

  state_e           state_q, state_d;
  logic [15:0]      min_q, min_d;
  logic [4:0]       id_q, id_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [15:0]      best_sad_q, best_sad_d;
  logic [4:0]       best_id_q, best_id_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [15:0]      fold_min;
  logic [4:0]       fold_id;
  logic [CNT_W-1:0] fold_cnt;

  // FIFO control: a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    pop      = (cnt_q != '0) && out_ready;
    push     = cal_valid && ((cnt_q < (AW+1)'(DEPTH)) || pop);
    drop     = cal_valid && !push;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // FIFO storage, no reset needed since reads are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cal_id, cal_rdata};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid          = (cnt_q != '0);
  assign {out_id, out_sad}  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_cnt           = cnt_q;
  assign ovf                = ovf_q;

  // Tracker next state: a frame_start reseeds the accumulators and folds
  // in a same-cycle sample; the summary registers are written on the edge
  // entering DONE so they are already valid while best_valid is high.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    id_d       = id_q;
    tcnt_d     = tcnt_q;
    best_sad_d = best_sad_q;
    best_id_d  = best_id_q;
    best_cnt_d = best_cnt_q;

    fold_min = frame_start ? '1 : min_q;
    fold_id  = frame_start ? '0 : id_q;
    fold_cnt = frame_start ? '0 : tcnt_q;
    if (cal_valid) begin
      if (!(&fold_cnt)) fold_cnt = fold_cnt + 1'b1;
      if (cal_rdata < fold_min) begin
        fold_min = cal_rdata;
        fold_id  = cal_id;
      end
    end

    if (frame_start) begin
      state_d = TRACK;
      min_d   = fold_min;
      id_d    = fold_id;
      tcnt_d  = fold_cnt;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        TRACK: begin
          min_d  = fold_min;
          id_d   = fold_id;
          tcnt_d = fold_cnt;
          if (frame_end) begin
            state_d    = DONE;
            best_sad_d = fold_min;
            best_id_d  = fold_id;
            best_cnt_d = fold_cnt;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Tracker state and summary registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      min_q      <= '1;
      id_q       <= '0;
      tcnt_q     <= '0;
      best_sad_q <= '0;
      best_id_q  <= '0;
      best_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      id_q       <= id_d;
      tcnt_q     <= tcnt_d;
      best_sad_q <= best_sad_d;
      best_id_q  <= best_id_d;
      best_cnt_q <= best_cnt_d;
    end
  end

  assign best_valid = (state_q == DONE);
  assign best_sad   = best_sad_q;
  assign best_id    = best_id_q;
  assign best_cnt   = best_cnt_q;

endmodule

// File: tb/tb_sad_result_collector.sv
// Self-checking bench for sad_result_collector: FIFO traffic is checked
// against a scoreboard queue, tracker summaries by directed checks.
module tb_sad_result_collector;

  localparam int DEPTH = 8;
  localparam int CNT_W = 6;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cal_valid = 1'b0;
  logic [4:0]       cal_id = '0;
  logic [15:0]      cal_rdata = '0;
  logic             frame_start = 1'b0;
  logic             frame_end = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [4:0]       out_id;
  logic [15:0]      out_sad;
  logic [AW:0]      fifo_cnt;
  logic             ovf;
  logic             best_valid;
  logic [15:0]      best_sad;
  logic [4:0]       best_id;
  logic [CNT_W-1:0] best_cnt;

  int checks   = 0;
  int failures = 0;

  logic [20:0] sb[$];
  logic        movf = 1'b0;

  sad_result_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cal_valid(cal_valid), .cal_id(cal_id),
    .cal_rdata(cal_rdata), .frame_start(frame_start), .frame_end(frame_end),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_sad(out_sad), .fifo_cnt(fifo_cnt), .ovf(ovf),
    .best_valid(best_valid), .best_sad(best_sad), .best_id(best_id),
    .best_cnt(best_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the capturing edge
  task automatic cyc(input logic v, input logic [4:0] id, input logic [15:0] sad,
                     input logic fs, input logic fe, input logic clr, input logic rdy);
    cal_valid   = v;
    cal_id      = id;
    cal_rdata   = sad;
    frame_start = fs;
    frame_end   = fe;
    ovf_clr     = clr;
    out_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare the head and occupancy, then apply this cycle's
  // push/pop/drop to the reference queue
  always @(negedge clk) begin
    int   n;
    logic pop, push;
    if (!rst_n) begin
      sb.delete();
      movf = 1'b0;
    end else begin
      n = sb.size();
      chk("fifo_cnt", 32'(fifo_cnt), n);
      chk("out_valid", 32'(out_valid), 32'(n != 0));
      chk("ovf", 32'(ovf), 32'(movf));
      if (n != 0) begin
        chk("out_id", 32'(out_id), 32'(sb[0][20:16]));
        chk("out_sad", 32'(out_sad), 32'(sb[0][15:0]));
      end
      pop  = (n != 0) && out_ready;
      push = cal_valid && ((n < DEPTH) || pop);
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({cal_id, cal_rdata});
      if (cal_valid && !push) movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
    chk("rst_best_valid", 32'(best_valid), 0);
    chk("rst_best_sad", 32'(best_sad), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming with downstream always ready
    for (int i = 1; i <= 5; i++) cyc(1'b1, 5'(i), 16'(i * 10), 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stream_empty", 32'(fifo_cnt), 0);

    // Overflow: ten pushes into an eight-deep stalled FIFO
    for (int i = 1; i <= 10; i++) cyc(1'b1, 5'(i), 16'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_full_cnt", 32'(fifo_cnt), DEPTH);
    chk("ovf_set", 32'(ovf), 1);
    repeat (9) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_drained", 32'(fifo_cnt), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", 32'(ovf), 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 1; i <= 8; i++) cyc(1'b1, 5'(i), 16'(200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_cnt", 32'(fifo_cnt), DEPTH);
    for (int i = 20; i <= 22; i++) cyc(1'b1, 5'(i), 16'(300 + i), 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_pp_cnt", 32'(fifo_cnt), DEPTH);
    chk("full_pp_ovf", 32'(ovf), 0);
    repeat (10) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_pp_drained", 32'(fifo_cnt), 0);

    // Tracking frame: minimum arrives together with frame_end
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd2, 16'd300, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd7, 16'd120, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd9, 16'd120, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd4, 16'd500, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd11, 16'd90, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("trk_best_valid", 32'(best_valid), 1);
    chk("trk_best_sad", 32'(best_sad), 90);
    chk("trk_best_id", 32'(best_id), 11);
    chk("trk_best_cnt", 32'(best_cnt), 5);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("trk_pulse_end", 32'(best_valid), 0);
    chk("trk_hold_sad", 32'(best_sad), 90);

    // Ties keep the earliest sample
    cyc(1'b1, 5'd3, 16'd40, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd6, 16'd40, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("tie_best_id", 32'(best_id), 3);
    chk("tie_best_cnt", 32'(best_cnt), 2);

    // Restart and empty frame
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 5'd1, 16'd50, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("empty_best_valid", 32'(best_valid), 1);
    chk("empty_best_sad", 32'(best_sad), 32'hFFFF);
    chk("empty_best_id", 32'(best_id), 0);
    chk("empty_best_cnt", 32'(best_cnt), 0);

    // Sample counter saturation
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 70; i++)
      cyc(1'b1, 5'(i % 32), 16'(1000 - i), 1'b0, (i == 69), 1'b0, 1'b1);
    chk("sat_best_cnt", 32'(best_cnt), 63);
    chk("sat_best_sad", 32'(best_sad), 931);
    chk("sat_best_id", 32'(best_id), 5);
    repeat (2) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame with three entries queued
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 5'(i), 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(fifo_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(fifo_cnt), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_id", 32'(out_id), 0);
    chk("mid_rst_sad", 32'(out_sad), 0);
    chk("mid_rst_ovf", 32'(ovf), 0);
    chk("mid_rst_best_sad", 32'(best_sad), 0);
    chk("mid_rst_best_id", 32'(best_id), 0);
    chk("mid_rst_best_cnt", 32'(best_cnt), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_no_best", 32'(best_valid), 0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_no_best2", 32'(best_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
